lane_gearbox_ser: RTL and testbench
===================================

Name: lane_gearbox_ser

Overview:
- Synchronous, parametrised TX gearbox. Accepts full-width parallel words for NUM_LANES lock-stepped lanes through a valid/ready handshake and buffers them in a small FIFO.
- Breaks each word into OUT_W-bit beats, one beat per clk, to feed the per-lane analog tree serializers.
- Adds framing, idle-pattern insertion, selectable bit order, underrun detection and a frame counter.
- Sits between the link-layer TX datapath and the latch/mux serializer trees.

Parameters:
- NUM_LANES, 4: number of lock-stepped lanes.
- DATA_W, 32: parallel word width per lane. Must be a multiple of OUT_W.
- OUT_W, 4: beat width per lane per clk. Equals the serializer tree input width.
- FIFO_DEPTH, 2: input buffer entries, 1..8.
- RATIO (derived): DATA_W/OUT_W, the number of beats per frame.

Ports:
- clk  in  1  clock (the serializer tree's slowest clock domain).
- rst  in  1  synchronous active-high reset.
- en  in  1  transmit enable.
- msb_first  in  1  bit-order select, sampled only at frame load.
- idle_pattern  in  OUT_W  beat driven on every lane when no data is sent.
- in_valid  in  1  word valid.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  NUM_LANES*DATA_W  lane L word = in_data[L*DATA_W +: DATA_W].
- out_valid  out  1  current beat carries data.
- out_data  out  NUM_LANES*OUT_W  lane L beat = out_data[L*OUT_W +: OUT_W]. Bit 0 is serialized first.
- underrun  out  1  one-cycle pulse when data flow breaks.
- frame_cnt  out  16  data frames started, saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; beat_cnt = RATIO-1.
  - out_valid=0, out_data = idle_pattern replicated per lane (registered), underrun=0, frame_cnt=0.
  - in_ready=0 while rst=1, and 1 on the first cycle after.
  - rst overrides all other inputs; a frame in progress is discarded.
- Handshake:
  - in_ready = !rst && (fifo_count < FIFO_DEPTH). It is a function of state only, never of in_valid.
  - A push occurs when in_valid && in_ready.
  - When full, in_ready stays 0 even if a pop happens in the same cycle (no pass-through).
  - A push and a pop in the same cycle are both performed.
- Beat counter:
  - While en=1, beat_cnt counts 0..RATIO-1 and wraps.
  - The edge at which beat_cnt==RATIO-1 is a frame boundary.
  - When RATIO==1, every edge is a boundary.
- At a boundary with en=1:
  - FIFO non-empty: pop the head into the shift register and latch msb_first. The next cycle shows beat 0 with out_valid=1. frame_cnt increments, saturating at 16'hFFFF.
  - FIFO empty: the next RATIO beats are idle_pattern with out_valid=0. If the previous frame carried data, underrun=1 for exactly the first idle beat.
- Beat content for beat k (0..RATIO-1), bit j, per lane:
  - LSB mode: word[k*OUT_W+j].
  - MSB mode: word[DATA_W-1-(k*OUT_W+j)].
- Minimum latency: a word pushed into an empty FIFO at edge e appears on the first edge after e that is a boundary. Latency is 1 to RATIO cycles.
- en deasserted:
  - The next edge forces beat_cnt=RATIO-1, out_valid=0, out_data=idle. Any partially sent word is aborted and dropped.
  - FIFO contents and pushes are unaffected. No underrun pulse.
  - Re-asserting en makes the next edge a boundary.
- idle_pattern and msb_first changes mid-frame do not affect a data frame already loaded. idle_pattern is sampled every idle beat.

Test Plan:
All scenarios use DATA_W=8, OUT_W=2, NUM_LANES=2, FIFO_DEPTH=2 (RATIO=4) unless stated.
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=idle_pattern x2, frame_cnt=0. The cycle after release, in_ready=1 and nothing is pushed during reset.
- LSB order: push lanes {0xB4, 0x1E} with en=1, msb_first=0 -> lane0 beats 0,1,3,2 and lane1 beats 2,3,1,0 on 4 consecutive cycles with out_valid=1. frame_cnt=1.
- MSB order and back-to-back: push 0xB4/0x1E then 0xC3/0x5A with msb_first=1 -> 8 contiguous valid beats. Lane0 output bits follow 0xB4 MSB first. No idle gap and underrun=0 between the frames.
- Backpressure: push 3 words without a pop boundary -> in_ready=0 after 2 pushes. The third word is held and accepted after the next pop; no word is lost or duplicated.
- Underrun: single word, no follow-on -> after 4 data beats, underrun=1 for exactly 1 cycle and out_valid=0 with out_data=idle_pattern. No further pulses while idle.
- Abort and RATIO=1: drop en at beat 2 -> beats 2-3 are dropped and idle is driven. After en returns, the next FIFO word starts at beat 0. Repeat with DATA_W=OUT_W=4 and verify one word per cycle at full throughput.

Source files
------------

// File: rtl/lane_gearbox_ser.sv
// lane_gearbox_ser: multi-lane TX gearbox splitting buffered words into OUT_W-bit beats with framing, idle fill and underrun flag
module lane_gearbox_ser #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       msb_first,
  input  logic [OUT_W-1:0]           idle_pattern,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic                       out_valid,
  output logic [NUM_LANES*OUT_W-1:0] out_data,
  output logic                       underrun,
  output logic [15:0]                frame_cnt
);
  localparam int RATIO = DATA_W / OUT_W;
  localparam int BW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = NUM_LANES * DATA_W;
  localparam int OW = NUM_LANES * OUT_W;
  localparam logic [BW-1:0] LAST = BW'(RATIO - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  logic [LW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] sh_q, sh_d, head, ld;
  logic [OW-1:0] od_q, od_d;
  logic          ov_q, ov_d, ur_q, ur_d;
  logic [15:0]   fc_q, fc_d;
  logic          push, pop, bnd;

  assign in_ready  = !rst && (cnt_q < CW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign bnd       = en && (beat_q == LAST);
  assign pop       = bnd && (cnt_q != '0);
  assign head      = mem_q[rd_q];
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign underrun  = ur_q;
  assign frame_cnt = fc_q;

  // load word is bit-reversed per lane in MSB mode so beats are always taken from the low end
  always_comb begin
    ld = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int i = 0; i < DATA_W; i++)
        ld[l*DATA_W+i] = msb_first ? head[l*DATA_W+DATA_W-1-i] : head[l*DATA_W+i];
  end

  // next beat: abort on en low, load at a boundary with data, otherwise shift or idle
  always_comb begin
    beat_d = !en ? LAST : bnd ? '0 : beat_q + BW'(1);
    ov_d   = !en ? 1'b0 : bnd ? pop : ov_q;
    ur_d   = bnd && !pop && ov_q;
    fc_d   = (pop && fc_q != 16'hFFFF) ? fc_q + 16'd1 : fc_q;
    sh_d   = '0;
    od_d   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      sh_d[l*DATA_W +: DATA_W] = pop ? ld[l*DATA_W +: DATA_W] >> OUT_W : sh_q[l*DATA_W +: DATA_W] >> OUT_W;
      od_d[l*OUT_W +: OUT_W]   = !ov_d ? idle_pattern : pop ? ld[l*DATA_W +: OUT_W] : sh_q[l*DATA_W +: OUT_W];
    end
  end

  // FIFO storage needs no reset; pushes are blocked while rst is high
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  // FIFO pointers, beat counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      beat_q <= LAST;
      ov_q   <= 1'b0;
      od_q   <= {NUM_LANES{idle_pattern}};
      ur_q   <= 1'b0;
      fc_q   <= '0;
      sh_q   <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
      if (pop) rd_q <= (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      beat_q <= beat_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      ur_q   <= ur_d;
      fc_q   <= fc_d;
      sh_q   <= sh_d;
    end
  end
endmodule

// File: tb/tb_lane_gearbox_ser.sv
// tb_lane_gearbox_ser: table-driven check of the gearbox at RATIO=4 and RATIO=1
module tb_lane_gearbox_ser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, msb_a, iv_a, ir_a, ov_a, ur_a;
  logic [1:0] idle_a;
  logic [15:0] id_a, fc_a;
  logic [3:0] od_a;
  logic rst_b, en_b, msb_b, iv_b, ir_b, ov_b, ur_b;
  logic [3:0] idle_b;
  logic [7:0] id_b, od_b;
  logic [15:0] fc_b;

  lane_gearbox_ser #(.NUM_LANES(2), .DATA_W(8), .OUT_W(2), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .msb_first(msb_a), .idle_pattern(idle_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a), .out_valid(ov_a),
    .out_data(od_a), .underrun(ur_a), .frame_cnt(fc_a));

  lane_gearbox_ser #(.NUM_LANES(2), .DATA_W(4), .OUT_W(4), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .msb_first(msb_b), .idle_pattern(idle_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b), .out_valid(ov_b),
    .out_data(od_b), .underrun(ur_b), .frame_cnt(fc_b));

  typedef struct {
    logic r, e, m;
    logic [3:0] idle;
    logic v;
    logic [15:0] d;
    logic rdy, ov;
    logic [7:0] od;
    logic ur;
    logic [15:0] fc;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic e, logic m, logic [3:0] idle, logic v, logic [15:0] d,
                              logic rdy, logic ov, logic [7:0] od, logic ur, logic [15:0] fc);
    vec_t t;
    t.r = r; t.e = e; t.m = m; t.idle = idle; t.v = v; t.d = d;
    t.rdy = rdy; t.ov = ov; t.od = od; t.ur = ur; t.fc = fc;
    return t;
  endfunction

  task automatic chk(input string n, input int s, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", n, s, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input bit b, input int s);
    @(negedge clk);
    if (!b) begin
      rst_a = t.r; en_a = t.e; msb_a = t.m; idle_a = t.idle[1:0]; iv_a = t.v; id_a = t.d;
    end else begin
      rst_b = t.r; en_b = t.e; msb_b = t.m; idle_b = t.idle; iv_b = t.v; id_b = t.d[7:0];
    end
    #1 chk(b ? "b_in_ready" : "a_in_ready", s, b ? 16'(ir_b) : 16'(ir_a), 16'(t.rdy));
    @(posedge clk);
    #1;
    chk(b ? "b_out_valid" : "a_out_valid", s, b ? 16'(ov_b) : 16'(ov_a), 16'(t.ov));
    chk(b ? "b_out_data" : "a_out_data", s, b ? 16'(od_b) : 16'(od_a), 16'(t.od));
    chk(b ? "b_underrun" : "a_underrun", s, b ? 16'(ur_b) : 16'(ur_a), 16'(t.ur));
    chk(b ? "b_frame_cnt" : "a_frame_cnt", s, b ? fc_b : fc_a, t.fc);
  endtask

  initial begin
    rst_a = 1; en_a = 0; msb_a = 0; idle_a = 1; iv_a = 0; id_a = 0;
    rst_b = 1; en_b = 0; msb_b = 0; idle_b = 4'hA; iv_b = 0; id_b = 0;
    for (int i = 0; i < 3; i++) va.push_back(mk(1, 1, 0, 1, 1, 16'h1EB4, 0, 0, 8'h5, 0, 0));
    va.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 8'h5, 0, 0));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 8'h5, 0, 0));
    va.push_back(mk(0, 1, 0, 1, 1, 16'h1EB4, 1, 0, 8'h5, 0, 0));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 8'h5, 0, 0));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 8'h5, 0, 0));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 8'h8, 0, 1));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 8'hD, 0, 1));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 8'h7, 0, 1));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 8'h2, 0, 1));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 8'h5, 1, 1));
    for (int i = 0; i < 3; i++) va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 8'h5, 0, 1));
    va.push_back(mk(0, 1, 0, 2, 0, 0, 1, 0, 8'hA, 0, 1));
    va.push_back(mk(0, 1, 1, 2, 1, 16'h1EB4, 1, 0, 8'hA, 0, 1));
    va.push_back(mk(0, 1, 1, 2, 1, 16'h5AC3, 1, 0, 8'hA, 0, 1));
    va.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 8'hA, 0, 1));
    va.push_back(mk(0, 1, 1, 2, 0, 0, 0, 1, 8'h1, 0, 2));
    va.push_back(mk(0, 1, 1, 2, 0, 0, 1, 1, 8'hB, 0, 2));
    va.push_back(mk(0, 1, 1, 2, 0, 0, 1, 1, 8'hE, 0, 2));
    va.push_back(mk(0, 1, 1, 2, 0, 0, 1, 1, 8'h4, 0, 2));
    va.push_back(mk(0, 1, 1, 2, 0, 0, 1, 1, 8'hB, 0, 3));
    va.push_back(mk(0, 1, 0, 2, 0, 0, 1, 1, 8'h8, 0, 3));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 8'h4, 0, 3));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 8'h7, 0, 3));
    va.push_back(mk(0, 1, 0, 3, 0, 0, 1, 0, 8'hF, 1, 3));
    va.push_back(mk(0, 1, 0, 0, 1, 16'h00E4, 1, 0, 8'h0, 0, 3));
    va.push_back(mk(0, 1, 0, 0, 1, 16'hFF1B, 1, 0, 8'h0, 0, 3));
    va.push_back(mk(0, 1, 0, 0, 1, 16'hAA55, 0, 0, 8'h0, 0, 3));
    va.push_back(mk(0, 1, 0, 0, 1, 16'hAA55, 0, 1, 8'h0, 0, 4));
    va.push_back(mk(0, 1, 0, 0, 1, 16'hAA55, 1, 1, 8'h1, 0, 4));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'h2, 0, 4));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'h3, 0, 4));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'hF, 0, 5));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'hE, 0, 5));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'hD, 0, 5));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'hC, 0, 5));
    for (int i = 0; i < 4; i++) va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h9, 0, 6));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 8'h0, 1, 6));
    va.push_back(mk(0, 1, 0, 0, 1, 16'h1EB4, 1, 0, 8'h0, 0, 6));
    va.push_back(mk(0, 1, 0, 0, 1, 16'h00E4, 1, 0, 8'h0, 0, 6));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h0, 0, 6));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'h8, 0, 7));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'hD, 0, 7));
    va.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h0, 0, 7));
    va.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h0, 0, 7));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h0, 0, 8));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h1, 0, 8));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h2, 0, 8));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h3, 0, 8));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 8'h0, 1, 8));
    foreach (va[i]) run(va[i], 1'b0, i);
    vb.push_back(mk(1, 1, 0, 4'hA, 1, 16'h00FF, 0, 0, 8'hAA, 0, 0));
    vb.push_back(mk(0, 1, 0, 4'hA, 1, 16'h0021, 1, 0, 8'hAA, 0, 0));
    vb.push_back(mk(0, 1, 0, 4'hA, 1, 16'h0043, 1, 1, 8'h21, 0, 1));
    vb.push_back(mk(0, 1, 1, 4'hA, 1, 16'h0065, 1, 1, 8'h2C, 0, 2));
    vb.push_back(mk(0, 1, 0, 4'hA, 0, 0, 1, 1, 8'h65, 0, 3));
    vb.push_back(mk(0, 1, 0, 4'hA, 0, 0, 1, 0, 8'hAA, 1, 3));
    vb.push_back(mk(0, 1, 0, 4'hA, 0, 0, 1, 0, 8'hAA, 0, 3));
    foreach (vb[i]) run(vb[i], 1'b1, i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
